// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - Load handshake and serial output bundle for piso_serializer.
interface piso_serializer_if #(
  parameter int SIZE = 256
);
  logic [SIZE-1:0] p_in;
  logic            load_valid;
  logic            load_ready;
  logic            hold;
  logic            s_out;
  logic            shift_out;
  logic            busy;
  logic            done;

  modport master (
    output p_in, load_valid, hold,
    input  load_ready, s_out, shift_out, busy, done
  );

  modport slave (
    input  p_in, load_valid, hold,
    output load_ready, s_out, shift_out, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - Parallel-in serial-out shifter, MSB first, with hold and done pulse.
module piso_serializer #(
  parameter int SIZE = 256
) (
  input  logic              clk,
  input  logic              reset,
  piso_serializer_if.slave  bus
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [SIZE-1:0] r_shreg;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            w_load_ready;
  logic            w_shift_out;
  logic            w_accept;
  logic            w_advance;
  logic            w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Reset gates load_ready so a word offered during reset is never taken.
  always_comb begin
    w_next_state = r_state;
    w_load_ready = 1'b0;
    w_shift_out  = 1'b0;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        w_load_ready = !reset;
        w_accept     = bus.load_valid && !reset;
        if (w_accept) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        w_shift_out = !bus.hold;
        w_advance   = !bus.hold;
        w_last      = w_advance && (r_cnt == CW'(1));
        if (w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_shreg <= bus.p_in;
        r_cnt   <= CW'(SIZE);
      end else if (w_advance) begin
        r_shreg <= {r_shreg[SIZE-2:0], 1'b0};
        r_cnt   <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.s_out      = r_shreg[SIZE-1];
  assign bus.shift_out  = w_shift_out;
  assign bus.busy       = (r_state == SHIFT);
  assign bus.done       = r_done;
  assign bus.load_ready = w_load_ready;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - Self-checking bench for piso_serializer (SIZE 8 and SIZE 256).
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piso_serializer_if #(.SIZE(8))   bus8 ();
  piso_serializer_if #(.SIZE(256)) bus256 ();

  piso_serializer #(.SIZE(8))   u_dut8   (.clk(clk), .reset(reset), .bus(bus8));
  piso_serializer #(.SIZE(256)) u_dut256 (.clk(clk), .reset(reset), .bus(bus256));

  typedef struct {
    logic [7:0]  word;
    logic [15:0] hold_mask;
    int          done_cycle;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;

  localparam logic [255:0] BIG_WORD =
    256'h477887da7844557a78545e784ff785487e1578785477887da78445aaaaaaaaaa;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop_compare(input string name, input logic [7:0] rx);
    if (sb_q.size() == 0) begin
      checkw({name, "_sb_empty"}, 256'(1), 256'(0));
    end else begin
      checkw(name, 256'(rx), 256'(sb_q.pop_front()));
    end
  endtask

  // One word with a per-cycle hold pattern; p_in and load_valid are scrambled while busy.
  task automatic run_word(input logic [7:0] w, input logic [15:0] mask, input int exp_done);
    int         sent;
    logic [7:0] rx;
    logic       h;
    bit         seen;
    sent = 0;
    rx   = '0;
    seen = 0;
    next_cycle();
    bus8.p_in       = w;
    bus8.load_valid = 1'b1;
    bus8.hold       = 1'b0;
    #1;
    check1("accept_ready", bus8.load_ready, 1'b1);
    sb_q.push_back(w);
    for (int c = 1; c <= 20 && !seen; c++) begin
      next_cycle();
      h               = (c <= 16) ? mask[c-1] : 1'b0;
      bus8.p_in       = 8'($urandom);
      bus8.load_valid = (c < exp_done) ? 1'($urandom) : 1'b0;
      bus8.hold       = h;
      #1;
      check1("shift_out", bus8.shift_out, (sent < 8) && !h);
      check1("busy", bus8.busy, sent < 8);
      check1("load_ready", bus8.load_ready, sent >= 8);
      check1("done", bus8.done, c == exp_done);
      if (bus8.shift_out) begin
        if (sent < 8) check1("s_out_bit", bus8.s_out, w[7-sent]);
        rx = {rx[6:0], bus8.s_out};
        sent++;
      end
      if (bus8.done) begin
        seen = 1;
        sb_pop_compare("word", rx);
      end
    end
    if (!seen) check1("done_timeout", 1'b0, 1'b1);
    bus8.load_valid = 1'b0;
    bus8.hold       = 1'b0;
  endtask

  initial begin
    logic [7:0]   rx;
    logic [255:0] p_out;
    logic [7:0]   w;
    int           bits;
    bit           seen;

    vecs[0] = '{8'hA5, 16'h0000, 9};
    vecs[1] = '{8'h3C, 16'h000C, 11};
    vecs[2] = '{8'hFF, 16'h0001, 10};
    vecs[3] = '{8'h01, 16'h0080, 10};
    vecs[4] = '{8'h96, 16'h002A, 12};
    vecs[5] = '{8'h00, 16'h0000, 9};

    reset             = 1'b1;
    bus8.p_in         = 8'h5A;
    bus8.load_valid   = 1'b1;
    bus8.hold         = 1'b0;
    bus256.p_in       = '0;
    bus256.load_valid = 1'b0;
    bus256.hold       = 1'b0;

    repeat (2) next_cycle();
    #1;
    check1("rst_s_out", bus8.s_out, 1'b0);
    check1("rst_shift_out", bus8.shift_out, 1'b0);
    check1("rst_busy", bus8.busy, 1'b0);
    check1("rst_done", bus8.done, 1'b0);
    check1("rst_load_ready", bus8.load_ready, 1'b0);
    check1("rst_load_ready_256", bus256.load_ready, 1'b0);

    next_cycle();
    bus8.load_valid = 1'b0;
    reset           = 1'b0;
    #1;
    check1("first_cycle_ready", bus8.load_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].word, vecs[i].hold_mask, vecs[i].done_cycle);
    end

    // Back-to-back: second word taken in the done cycle of the first.
    next_cycle();
    bus8.p_in       = 8'hFF;
    bus8.load_valid = 1'b1;
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'h01);
    rx   = '0;
    bits = 0;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      bus8.p_in       = 8'h01;
      bus8.load_valid = (c <= 9);
      #1;
      check1("b2b_done", bus8.done, (c == 9) || (c == 18));
      check1("b2b_shift_out", bus8.shift_out, (c != 9) && (c <= 17));
      if (bus8.shift_out) begin
        rx = {rx[6:0], bus8.s_out};
        bits++;
      end
      if (bus8.done) sb_pop_compare("b2b_word", rx);
    end
    checkw("b2b_bits", 256'(bits), 256'(16));
    bus8.load_valid = 1'b0;

    // Reset in the middle of a word aborts it silently.
    w = 8'hC3;
    next_cycle();
    bus8.p_in       = w;
    bus8.load_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      bus8.load_valid = 1'b0;
      #1;
      check1("abort_shift_out", bus8.shift_out, 1'b1);
      check1("abort_s_out", bus8.s_out, w[8-c]);
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check1("abort_busy", bus8.busy, 1'b0);
    check1("abort_shift_out_after", bus8.shift_out, 1'b0);
    check1("abort_s_out_after", bus8.s_out, 1'b0);
    check1("abort_done", bus8.done, 1'b0);
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      #1;
      check1("abort_no_done", bus8.done, 1'b0);
      check1("abort_no_shift", bus8.shift_out, 1'b0);
    end
    run_word(8'h81, 16'h0000, 9);

    // Full-width word into a receiver model.
    next_cycle();
    bus256.p_in       = BIG_WORD;
    bus256.load_valid = 1'b1;
    #1;
    check1("big_accept_ready", bus256.load_ready, 1'b1);
    p_out = '0;
    seen  = 0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      next_cycle();
      bus256.load_valid = 1'b0;
      bus256.p_in       = ~BIG_WORD;
      #1;
      if (bus256.shift_out) p_out = {p_out[254:0], bus256.s_out};
      if (bus256.done) begin
        seen = 1;
        checkw("big_done_cycle", 256'(c), 256'(257));
        checkw("big_word", p_out, BIG_WORD);
      end
    end
    if (!seen) check1("big_done_timeout", 1'b0, 1'b1);
    checkw("sb_leftover", 256'(sb_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter SIZE, default 256, word width in bits (minimum 2).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 p_in  input  SIZE  parallel word to transmit.
REQ-005 load_valid  input  1  p_in holds a word to send.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 hold  input  1  pause request; freezes shifting while high.
REQ-008 s_out  output  1  serial data bit, MSB first.
REQ-009 shift_out  output  1  s_out is valid this cycle; drives a receiver's shift input.
REQ-010 busy  output  1  a word is in flight.
REQ-011 done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-012 Internal state: two-state FSM IDLE/SHIFT, SIZE-bit shift register shreg, bit counter cnt of width clog2(SIZE+1), registered done flag.
REQ-013 load_ready SHALL be 1 iff state==IDLE and reset==0.
REQ-014 Accept: a word is accepted at a rising edge where load_valid && load_ready. On acceptance shreg<=p_in, cnt<=SIZE, state<=SHIFT.
REQ-015 In IDLE, load_valid==0: shreg and cnt hold, state stays IDLE.
REQ-016 s_out SHALL equal shreg[SIZE-1] at all times (register bit, no combinational path from inputs).
REQ-017 shift_out SHALL equal (state==SHIFT) && !hold, combinationally.
REQ-018 SHIFT edge with hold==0: shreg<=shreg<<1 with 0 into bit 0, cnt<=cnt-1.
REQ-019 SHIFT edge with hold==1: shreg, cnt and state unchanged; shift_out 0 that cycle.
REQ-020 SHIFT edge with hold==0 and cnt==1 (last bit): state<=IDLE, done<=1.
REQ-021 done SHALL be 1 for exactly the one cycle following the last-bit edge, else 0.
REQ-022 Bit order: first shift_out cycle presents p_in[SIZE-1], the k-th presents p_in[SIZE-k], the last presents p_in[0]. A receiver shifting left with bit-0 insertion reconstructs p_in exactly.
REQ-023 Latency without hold: accept at edge N; bits in cycles N+1..N+SIZE; done and load_ready high in cycle N+SIZE+1.
REQ-024 Back-to-back: a new word MAY be accepted in the done cycle. Sustained throughput SHALL be one word per SIZE+1 cycles.
REQ-025 Each hold cycle SHALL extend the word by exactly one cycle. No bit is dropped or duplicated.
REQ-026 busy SHALL equal (state==SHIFT).
REQ-027 p_in and load_valid are ignored while state==SHIFT. p_in changes after acceptance SHALL NOT affect the word in flight.
REQ-028 cnt SHALL never underflow. cnt==0 is only reachable in IDLE.

Reset
REQ-029 When reset is high at a rising edge: state<=IDLE, shreg<=0, cnt<=0, done<=0.
REQ-030 Resulting output values: s_out=0, shift_out=0, busy=0, done=0, load_ready=0 while reset is held high, load_ready=1 the first cycle reset is low.
REQ-031 Reset has priority over load, hold and shift in the same cycle.
REQ-032 Reset during SHIFT SHALL abort the word silently: no done pulse, and no further shift_out until a new accept.

Verification
REQ-033 SIZE=8, p_in=8'hA5, load_valid for one cycle, hold=0 -> shift_out high 8 consecutive cycles, s_out=1,0,1,0,0,1,0,1, done pulse in the 9th cycle, busy low in that cycle.
REQ-034 SIZE=8, p_in=8'h3C, hold high in cycles 3 and 4 of the word -> shift_out low in exactly those 2 cycles, s_out sequence 0,0,1,1,1,1,0,0, done 2 cycles later than in REQ-033.
REQ-035 SIZE=8, load_valid held high with words 8'hFF then 8'h01 -> second word accepted in the done cycle of the first, 16 bits delivered over 18 cycles, receiver model reads FF then 01.
REQ-036 SIZE=8, reset asserted after the 4th bit of 8'hC3 -> next cycle busy=0, shift_out=0, s_out=0, and no done pulse. A following word 8'h81 is delivered intact.
REQ-037 SIZE=256, p_in=256'h477887da7844557a78545e784ff785487e1578785477887da78445aaaaaaaaaa into a sipo_shift_register model with reset released -> model p_out equals p_in after done, and done asserts 257 cycles after acceptance.
REQ-038 p_in changed every cycle during SHIFT, with load_valid toggling -> the transmitted word is the value captured at acceptance, and no accept occurs while busy=1.
